// File: rtl/pc_register_unit.sv
// rtl/pc_register_unit.sv - A/D/PC register file with an ack-gated RAM[A] write path
module pc_register_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        ctrl_valid,
  input  logic [15:0] R,
  input  logic        a,
  input  logic        d,
  input  logic        addr_a,
  input  logic        j,
  input  logic        mem_ack,
  output logic [15:0] A_q,
  output logic [15:0] D_q,
  output logic [15:0] PC,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        instr_done
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic [15:0] reg_a_q, reg_a_d;
  logic [15:0] reg_d_q, reg_d_d;
  logic [15:0] pc_q, pc_d;
  logic        mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        lat_a_q, lat_a_d;
  logic        lat_d_q, lat_d_d;
  logic        lat_j_q, lat_j_d;
  logic        done_q, done_d;

  logic        commit;
  logic [15:0] c_r, c_old;
  logic        c_a, c_d, c_j;

  // mem_addr_q/mem_wdata_q double as the latched old A and R for the deferred commit
  always_comb begin
    state_d     = state_q;
    reg_a_d     = reg_a_q;
    reg_d_d     = reg_d_q;
    pc_d        = pc_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    lat_a_d     = lat_a_q;
    lat_d_d     = lat_d_q;
    lat_j_d     = lat_j_q;
    done_d      = 1'b0;
    commit      = 1'b0;
    c_r         = R;
    c_a         = a;
    c_d         = d;
    c_j         = j;
    c_old       = reg_a_q;
    case (state_q)
      IDLE: begin
        if (run && ctrl_valid) begin
          if (addr_a) begin
            mem_addr_d  = reg_a_q;
            mem_wdata_d = R;
            mem_wr_d    = 1'b1;
            lat_a_d     = a;
            lat_d_d     = d;
            lat_j_d     = j;
            state_d     = WRITE;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WRITE: begin
        if (mem_ack) begin
          commit   = 1'b1;
          c_r      = mem_wdata_q;
          c_a      = lat_a_q;
          c_d      = lat_d_q;
          c_j      = lat_j_q;
          c_old    = mem_addr_q;
          mem_wr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      if (c_a) reg_a_d = c_r;
      if (c_d) reg_d_d = c_r;
      pc_d   = c_j ? c_old : pc_q + 16'd1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      reg_a_q     <= 16'h0000;
      reg_d_q     <= 16'h0000;
      pc_q        <= RESET_PC;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      lat_a_q     <= 1'b0;
      lat_d_q     <= 1'b0;
      lat_j_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_a_q     <= reg_a_d;
      reg_d_q     <= reg_d_d;
      pc_q        <= pc_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      lat_a_q     <= lat_a_d;
      lat_d_q     <= lat_d_d;
      lat_j_q     <= lat_j_d;
      done_q      <= done_d;
    end
  end

  assign A_q        = reg_a_q;
  assign D_q        = reg_d_q;
  assign PC         = pc_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q == WRITE);
  assign instr_done = done_q;

endmodule
